pkt_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one packet_ctrl transmit path between NUM_REQ requesters. It grants the path one whole packet at a time, and only while the link is UP (link_state==2'b11). It latches the winner's DATA_WIDTH word and drives the pkt_req/data handshake into packet_ctrl. It releases the grant on pkt_eop, on link loss, or on a packet-length overrun.

---
 rtl/pkt_tx_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_pkt_tx_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pkt_tx_arbiter.sv
// Round-robin arbiter sharing one packet_ctrl transmit path, one whole packet per grant.
// Optional PKT_ARB_PRIO0_EN: requester 0 gets strict priority; the others rotate among themselves.
module pkt_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int PKT_WIDTH  = 8,
  parameter int PKT_LENGTH = 4,
  parameter int DATA_WIDTH = PKT_WIDTH * PKT_LENGTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    link_state,
  input  logic                          link_down,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          pkt_ack,
  input  logic                          pkt_sop,
  input  logic                          pkt_eop,
  output logic                          pkt_req,
  output logic [DATA_WIDTH-1:0]         data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [NUM_REQ-1:0]            abort,
  output logic                          len_err,
  output logic                          busy
);

  localparam int PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PLEN_WIDTH = (PKT_LENGTH > 1) ? $clog2(PKT_LENGTH) : 1;
  localparam int BCW        = PLEN_WIDTH + 1;
  localparam logic [BCW-1:0]   PLEN = BCW'(PKT_LENGTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, XFER} state_t;

  state_t                  state, state_nxt;
  logic [PTR_W-1:0]        rr_ptr, rr_nxt;
  logic [PTR_W-1:0]        cur_idx, cur_nxt;
  logic [BCW-1:0]          beat_cnt, beat_nxt;
  logic [NUM_REQ-1:0]      gnt_nxt, done_nxt, abort_nxt;
  logic                    pkt_req_nxt, len_err_nxt;
  logic [DATA_WIDTH-1:0]   data_nxt;
  logic                    link_up, win_vld, cnt_en, rel;
  logic [PTR_W-1:0]        win_idx, scan_idx;

  function automatic logic [PTR_W-1:0] adv_ptr(input logic [PTR_W-1:0] idx);
`ifdef PKT_ARB_PRIO0_EN
    adv_ptr = (idx == LAST) ? PTR_W'(1) : idx + 1'b1;
`else
    adv_ptr = (idx == LAST) ? '0 : idx + 1'b1;
`endif
  endfunction

  assign link_up = (link_state == 2'b11) && !link_down;
  assign busy    = (state != IDLE);

  // Winner search: first set request at or after rr_ptr, wrapping.
`ifdef PKT_ARB_PRIO0_EN
  logic [PTR_W-1:0] scan_start;
  always_comb begin
    int j;
    win_vld    = 1'b0;
    win_idx    = '0;
    scan_idx   = '0;
    scan_start = (rr_ptr == '0) ? PTR_W'(1) : rr_ptr;
    if (req[0]) begin
      win_vld = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ - 1; k++) begin
        j = int'(scan_start) + k;
        if (j > NUM_REQ - 1) j = j - (NUM_REQ - 1);
        scan_idx = PTR_W'(j);
        if (!win_vld && req[scan_idx]) begin
          win_vld = 1'b1;
          win_idx = scan_idx;
        end
      end
    end
  end
`else
  always_comb begin
    int j;
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      scan_idx = PTR_W'(j);
      if (!win_vld && req[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end
`endif

  always_comb begin
    state_nxt   = state;
    rr_nxt      = rr_ptr;
    cur_nxt     = cur_idx;
    beat_nxt    = beat_cnt;
    gnt_nxt     = gnt;
    pkt_req_nxt = pkt_req;
    data_nxt    = data;
    done_nxt    = '0;
    abort_nxt   = '0;
    len_err_nxt = 1'b0;
    cnt_en      = 1'b0;
    rel         = 1'b0;
    case (state)
      IDLE: begin
        if (link_up && win_vld) begin
          state_nxt   = WAIT_ACK;
          cur_nxt     = win_idx;
          pkt_req_nxt = 1'b1;
          gnt_nxt     = '0;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
              gnt_nxt[i] = 1'b1;
              data_nxt   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end
      WAIT_ACK: begin
        // Link loss before acceptance retries the same requester: rr_ptr stays.
        if (!link_up) begin
          abort_nxt   = gnt;
          gnt_nxt     = '0;
          pkt_req_nxt = 1'b0;
          state_nxt   = IDLE;
        end else if (pkt_ack) begin
          pkt_req_nxt = 1'b0;
          beat_nxt    = '0;
          state_nxt   = XFER;
        end
      end
      XFER: begin
        cnt_en = pkt_sop || (beat_cnt != '0);
        if (cnt_en) beat_nxt = beat_cnt + 1'b1;
        if (!link_up) begin
          abort_nxt = gnt;
          rel       = 1'b1;
        end else if (pkt_eop) begin
          done_nxt = gnt;
          rel      = 1'b1;
        end else if (cnt_en && ((beat_cnt + 1'b1) == PLEN)) begin
          len_err_nxt = 1'b1;
          abort_nxt   = gnt;
          rel         = 1'b1;
        end
        if (rel) begin
          gnt_nxt   = '0;
          beat_nxt  = '0;
          state_nxt = IDLE;
`ifdef PKT_ARB_PRIO0_EN
          if (cur_idx != '0) rr_nxt = adv_ptr(cur_idx);
`else
          rr_nxt = adv_ptr(cur_idx);
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      cur_idx  <= '0;
      beat_cnt <= '0;
      gnt      <= '0;
      pkt_req  <= 1'b0;
      data     <= '0;
      done     <= '0;
      abort    <= '0;
      len_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      cur_idx  <= cur_nxt;
      beat_cnt <= beat_nxt;
      gnt      <= gnt_nxt;
      pkt_req  <= pkt_req_nxt;
      data     <= data_nxt;
      done     <= done_nxt;
      abort    <= abort_nxt;
      len_err  <= len_err_nxt;
    end
  end

endmodule

// File: tb/tb_pkt_tx_arbiter.sv
// Randomized bench for pkt_tx_arbiter against a transaction-level reference model.
// Honours PKT_ARB_PRIO0_EN when defined for the build.
module tb_pkt_tx_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int PKT_WIDTH  = 8;
  localparam int PKT_LENGTH = 4;
  localparam int DATA_WIDTH = PKT_WIDTH * PKT_LENGTH;
  localparam int NCYC       = 3000;
  localparam int RST_CYC    = 1200;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [1:0]                    link_state;
  logic                          link_down;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          pkt_ack, pkt_sop, pkt_eop;
  logic                          pkt_req;
  logic [DATA_WIDTH-1:0]         data;
  logic [NUM_REQ-1:0]            gnt, done, abort;
  logic                          len_err, busy;

  pkt_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .PKT_WIDTH(PKT_WIDTH), .PKT_LENGTH(PKT_LENGTH), .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .link_state(link_state), .link_down(link_down),
    .req(req), .req_data(req_data), .pkt_ack(pkt_ack), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
    .pkt_req(pkt_req), .data(data), .gnt(gnt), .done(done), .abort(abort),
    .len_err(len_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: packet ownership and expected outputs.
  int                    m_phase;   // 0 no owner, 1 offered, 2 transferring
  int                    m_owner, m_rr, m_beats;
  logic [NUM_REQ-1:0]    exp_gnt, exp_done, exp_abort;
  logic                  exp_req, exp_len;
  logic [DATA_WIDTH-1:0] exp_data;
  logic [DATA_WIDTH-1:0] pay [NUM_REQ];
  logic [NUM_REQ-1:0]    pending;
  int                    pc_idx, pc_len, down_cnt;
  bit                    pc_started;

  // Winner = set request with the smallest rotational distance from the pointer.
  function automatic int pick(input logic [NUM_REQ-1:0] r, input int rr);
    int best = -1, bd = NUM_REQ + 1, d;
`ifdef PKT_ARB_PRIO0_EN
    int rs = (rr == 0) ? 1 : rr;
    if (r[0]) return 0;
    for (int i = 1; i < NUM_REQ; i++)
      if (r[i]) begin
        d = ((i - 1) - (rs - 1) + (NUM_REQ - 1)) % (NUM_REQ - 1);
        if (d < bd) begin bd = d; best = i; end
      end
`else
    for (int i = 0; i < NUM_REQ; i++)
      if (r[i]) begin
        d = (i - rr + NUM_REQ) % NUM_REQ;
        if (d < bd) begin bd = d; best = i; end
      end
`endif
    return best;
  endfunction

  function automatic int next_rr(input int owner, input int rr);
`ifdef PKT_ARB_PRIO0_EN
    if (owner == 0) return rr;
    return (owner % (NUM_REQ - 1)) + 1;
`else
    return (owner + 1) % NUM_REQ;
`endif
  endfunction

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_rr = 0; m_beats = 0;
    exp_gnt = '0; exp_done = '0; exp_abort = '0; exp_req = 1'b0; exp_len = 1'b0;
    exp_data = '0; pending = '0; pc_idx = 0; pc_len = 0; pc_started = 0; down_cnt = 0;
  endtask

  task automatic finish_pkt(input bit ok, input bit ovr);
    if (ok) exp_done = exp_gnt; else exp_abort = exp_gnt;
    exp_len = ovr;
    exp_gnt = '0;
    m_rr    = next_rr(m_owner, m_rr);
    m_phase = 0;
  endtask

  task automatic model_step();
    bit lu, counted;
    lu = (link_state == 2'b11) && !link_down;
    exp_done = '0; exp_abort = '0; exp_len = 1'b0;
    case (m_phase)
      0: if (lu && req != '0) begin
        m_owner  = pick(req, m_rr);
        exp_gnt  = NUM_REQ'(1) << m_owner;
        exp_data = pay[m_owner];
        exp_req  = 1'b1;
        m_phase  = 1;
      end
      1: if (!lu) begin
        exp_abort = exp_gnt; exp_gnt = '0; exp_req = 1'b0; m_phase = 0;
      end else if (pkt_ack) begin
        exp_req = 1'b0; m_beats = 0; m_phase = 2;
        pc_idx = 0; pc_started = 0;
        case ($urandom % 8)
          0:       pc_len = PKT_LENGTH + 2;
          1:       pc_len = 1 + int'($urandom % (PKT_LENGTH - 1));
          default: pc_len = PKT_LENGTH;
        endcase
      end
      default: begin
        counted = pkt_sop || (m_beats > 0);
        if (counted) m_beats++;
        if (!lu) finish_pkt(0, 0);
        else if (pkt_eop) finish_pkt(1, 0);
        else if (counted && m_beats == PKT_LENGTH) finish_pkt(0, 1);
      end
    endcase
  endtask

  task automatic compare_outputs();
    check("gnt", 64'(gnt), 64'(exp_gnt));
    check("pkt_req", 64'(pkt_req), 64'(exp_req));
    check("data", 64'(data), 64'(exp_data));
    check("done", 64'(done), 64'(exp_done));
    check("abort", 64'(abort), 64'(exp_abort));
    check("len_err", 64'(len_err), 64'(exp_len));
    check("busy", 64'(busy), 64'(m_phase != 0));
  endtask

  task automatic drive_inputs();
    int r;
    pending = pending & ~(exp_done | exp_abort);
    if (m_phase != 0 && ($urandom % 16) == 0) pending[m_owner] = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pending[i] && ($urandom % 4) == 0) pending[i] = 1'b1;
      pay[i] = $urandom;
      req_data[i*DATA_WIDTH +: DATA_WIDTH] = pay[i];
    end
    req = pending;
    pkt_ack = (m_phase == 1) && (($urandom % 3) == 0);
    pkt_sop = 1'b0; pkt_eop = 1'b0;
    if (m_phase == 2) begin
      if (!pc_started && ($urandom % 2) == 0) begin pkt_sop = 1'b1; pc_started = 1; end
      else if (pc_started) pc_idx = pc_idx;
      if (pc_started) begin
        pc_idx++;
        pkt_eop = (pc_idx == pc_len);
      end
    end
    link_down = 1'b0;
    if (down_cnt > 0) begin
      down_cnt--;
    end else begin
      link_state = 2'b11;
      r = int'($urandom % 80);
      if (r < 2) link_down = 1'b1;
      else if (r == 2) begin
        down_cnt   = 1 + int'($urandom % 5);
        link_state = 2'($urandom % 3);
      end
    end
  endtask

  initial begin
    rst = 1'b1; link_state = 2'b00; link_down = 1'b0; req = '0; req_data = '0;
    pkt_ack = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) pay[i] = '0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_outputs();
    rst = 1'b0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      compare_outputs();
      if (cyc == RST_CYC) begin
        rst = 1'b1;
        #1;
        model_reset();
        compare_outputs();
      end else begin
        if (cyc == RST_CYC + 1) rst = 1'b0;
        drive_inputs();
        model_step();
      end
    end
    @(negedge clk);
    compare_outputs();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
